// File: rtl/memory_access_stage.sv
// MemoryAccess pipeline stage: passes ALU results through and runs load/store
// transactions on a req/ack data-memory port, producing the Writeback pipe register.
module memory_access_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic              in_is_load_i,
    input  logic              in_is_store_i,
    input  logic [2:0]        in_funct3_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_store_data_i,
    input  logic [DATA_W-1:0] in_alu_result_i,
    input  logic [4:0]        in_rd_addr_i,
    input  logic              in_rd_wr_enable_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_byte_en_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              misaligned_o,
    output logic              out_valid_o,
    output logic [4:0]        out_rd_addr_o,
    output logic              out_rd_wr_enable_o,
    output logic [DATA_W-1:0] out_rd_data_o
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e state_q, state_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              misaligned_q, misaligned_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_rd_addr_q, out_rd_addr_d;
    logic              out_rd_we_q, out_rd_we_d;
    logic [DATA_W-1:0] out_rd_data_q, out_rd_data_d;

    // Transaction context captured at acceptance
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        byte_off_q, byte_off_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_we_q, rd_we_d;

    logic              mem_op;
    logic              misalign_c;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] shifted_c;
    logic [DATA_W-1:0] load_data_c;

    assign mem_op = in_valid_i & (in_is_load_i | in_is_store_i);

    always_comb begin
        misalign_c = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = in_store_data_i;
        case (in_funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << in_addr_i[1:0];
                wdata_c = {4{in_store_data_i[7:0]}};
            end
            2'b01: begin
                misalign_c = in_addr_i[0];
                be_c       = 4'b0011 << in_addr_i[1:0];
                wdata_c    = {2{in_store_data_i[15:0]}};
            end
            default: begin
                misalign_c = |in_addr_i[1:0];
            end
        endcase
    end

    // Bit 2 of funct3 selects zero extension (BU/HU)
    always_comb begin
        shifted_c   = mem_rdata_i >> {byte_off_q, 3'b000};
        load_data_c = shifted_c;
        case (funct3_q[1:0])
            2'b00:   load_data_c = {{24{~funct3_q[2] & shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_data_c = {{16{~funct3_q[2] & shifted_c[15]}}, shifted_c[15:0]};
            default: load_data_c = shifted_c;
        endcase
    end

    assign stall_o = (state_q == StBusy) |
                     ((state_q == StIdle) & mem_op & ~misalign_c);

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        misaligned_d  = 1'b0;
        out_valid_d   = out_valid_q;
        out_rd_addr_d = out_rd_addr_q;
        out_rd_we_d   = out_rd_we_q;
        out_rd_data_d = out_rd_data_q;
        is_load_d     = is_load_q;
        funct3_d      = funct3_q;
        byte_off_d    = byte_off_q;
        rd_addr_d     = rd_addr_q;
        rd_we_d       = rd_we_q;

        unique case (state_q)
            StIdle: begin
                if (mem_op && misalign_c) begin
                    misaligned_d  = 1'b1;
                    out_valid_d   = 1'b1;
                    out_rd_addr_d = in_rd_addr_i;
                    out_rd_we_d   = 1'b0;
                    out_rd_data_d = in_alu_result_i;
                end else if (mem_op) begin
                    state_d     = StBusy;
                    mem_req_d   = 1'b1;
                    mem_we_d    = in_is_store_i;
                    mem_addr_d  = {in_addr_i[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = wdata_c;
                    mem_be_d    = be_c;
                    out_valid_d = 1'b0;
                    is_load_d   = in_is_load_i;
                    funct3_d    = in_funct3_i;
                    byte_off_d  = in_addr_i[1:0];
                    rd_addr_d   = in_rd_addr_i;
                    rd_we_d     = in_rd_wr_enable_i;
                end else begin
                    out_valid_d   = in_valid_i;
                    out_rd_addr_d = in_rd_addr_i;
                    out_rd_we_d   = in_rd_wr_enable_i;
                    out_rd_data_d = in_alu_result_i;
                end
            end
            StBusy: begin
                if (mem_ack_i) begin
                    state_d       = StIdle;
                    mem_req_d     = 1'b0;
                    out_valid_d   = 1'b1;
                    out_rd_addr_d = rd_addr_q;
                    out_rd_we_d   = is_load_q & rd_we_q;
                    out_rd_data_d = is_load_q ? load_data_c : '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= 4'b0000;
            misaligned_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_rd_addr_q <= 5'd0;
            out_rd_we_q   <= 1'b0;
            out_rd_data_q <= '0;
            is_load_q     <= 1'b0;
            funct3_q      <= 3'd0;
            byte_off_q    <= 2'd0;
            rd_addr_q     <= 5'd0;
            rd_we_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            misaligned_q  <= misaligned_d;
            out_valid_q   <= out_valid_d;
            out_rd_addr_q <= out_rd_addr_d;
            out_rd_we_q   <= out_rd_we_d;
            out_rd_data_q <= out_rd_data_d;
            is_load_q     <= is_load_d;
            funct3_q      <= funct3_d;
            byte_off_q    <= byte_off_d;
            rd_addr_q     <= rd_addr_d;
            rd_we_q       <= rd_we_d;
        end
    end

    assign mem_req_o          = mem_req_q;
    assign mem_we_o           = mem_we_q;
    assign mem_addr_o         = mem_addr_q;
    assign mem_wdata_o        = mem_wdata_q;
    assign mem_byte_en_o      = mem_be_q;
    assign misaligned_o       = misaligned_q;
    assign out_valid_o        = out_valid_q;
    assign out_rd_addr_o      = out_rd_addr_q;
    assign out_rd_wr_enable_o = out_rd_we_q;
    assign out_rd_data_o      = out_rd_data_q;

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline stage directly downstream of Execute: it consumes the Execute result register (ALU result, effective address, store data, destination-register control) and produces the MemoryAccess→Writeback pipeline register. Non-memory instructions pass through in one cycle. Loads and stores run a request/acknowledge transaction on the data-memory port, stalling the pipeline until the transaction completes. The stage generates RV32 byte enables, store-lane replication, load extraction with sign/zero extension, and misalignment detection.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, byte lanes = 4

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- inValid  in  1  Execute result valid this cycle
- inIsLoad  in  1  load instruction
- inIsStore  in  1  store instruction; inIsLoad and inIsStore are never both 1
- inFunct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- inAddr  in  ADDR_W  effective address
- inStoreData  in  DATA_W  rs2 value, already bypassed
- inAluResult  in  DATA_W  result for non-load instructions
- inRdAddr  in  5  destination register
- inRdWrEnable  in  1  destination write enable
- stall  out  1  freeze Execute and all upstream stages
- memReq  out  1  data-memory request, registered
- memWe  out  1  1 = store
- memAddr  out  ADDR_W  word-aligned address ({inAddr[31:2],2'b00})
- memWData  out  DATA_W  store data, lane-replicated
- memByteEn  out  4  byte enables
- memAck  in  1  transaction complete; read data valid when memWe = 0
- memRData  in  DATA_W  read word
- misaligned  out  1  one-cycle pulse on a misaligned access
- outValid, outRdAddr (5), outRdWrEnable (1), outRdData (DATA_W)  out  registered Writeback pipe register; also the Controller's bypass source

## Operation
- FSM states: IDLE, BUSY.
- Memory op = inValid & (inIsLoad | inIsStore).
- Misaligned = H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
- Reset: state IDLE; memReq, memWe, memAddr, memWData, memByteEn, misaligned, outValid, outRdAddr, outRdWrEnable and outRdData all 0.
- IDLE, non-memory op: next edge loads outValid = inValid, outRdAddr, outRdWrEnable, outRdData = inAluResult.
- IDLE, misaligned memory op: no request. Pulse misaligned for one cycle. Output register gets outValid = 1, outRdWrEnable = 0.
- IDLE, aligned memory op: latch op, funct3, addr[1:0] and rd control. Drive memReq = 1 and memWe / memAddr / memByteEn / memWData from the next edge. Go to BUSY. outValid = 0.
- Byte enables: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111.
- Store lane replication: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
- BUSY: all request signals held stable until memAck. On the memAck edge: memReq → 0, state → IDLE, outValid = 1.
  - Load: outRdData = selected byte/half (shifted by latched addr[1:0]), sign-extended for B/H and zero-extended for BU/HU.
  - Store: outRdWrEnable = 0.
- stall = (state == BUSY) | (IDLE & aligned memory op). stall is combinational; the upstream Execute register holds while it is asserted.
- memAck in IDLE is ignored.
- inValid = 0 in IDLE yields outValid = 0 at the next edge.

## Timing
- Non-memory op: result in the output register 1 cycle after acceptance.
- Memory op accepted in cycle T: memReq high from T+1. If memAck arrives in cycle T+1+k (k ≥ 0), outValid = 1 at T+2+k. stall is high in cycles T … T+1+k.
- The next instruction is accepted in cycle T+2+k; back-to-back memory ops leave exactly one IDLE cycle between requests.
- Reset asserted mid-transaction forces memReq low asynchronously; the memory slave must tolerate an abandoned request.
- Outputs change only on clk edges, except stall.

## Test plan
- ALU pass-through: inValid = 1, inAluResult = 0x1234_5678, rd = 5 → next cycle outValid = 1, outRdData = 0x1234_5678, outRdAddr = 5, stall = 0.
- LB, addr 0x1003, memRData = 0x80FF_FFFF, ack after 2 wait cycles → memByteEn = 1000, memAddr = 0x1000, stall held 4 cycles, outRdData = 0xFFFF_FF80. Same case as LBU → 0x0000_0080.
- SH, addr 0x2002, data 0x0000_BEEF → memWe = 1, memByteEn = 1100, memWData = 0xBEEF_BEEF, outRdWrEnable = 0 after ack.
- LW at 0x3001 → misaligned pulses 1 cycle, memReq stays 0, stall = 0, outValid = 1, outRdWrEnable = 0.
- Back-to-back LW / SW with ack in the same cycle as the request → each completes in 2 cycles; request signals are stable while memAck = 0; a spurious memAck in IDLE has no effect.
- rst low during BUSY → memReq and outValid drop immediately; after release the FSM is in IDLE and a fresh LW completes normally.
